// File: rtl/ibex_rvfi_trace_sink_pkg.sv
// Shared types and helpers for the RVFI trace sink: record layout, word selector, packet word builder.
package ibex_rvfi_trace_sink_pkg;

    localparam logic [3:0]  TRACE_SYNC = 4'hA;
    localparam int unsigned OrderW     = 17;
    localparam int unsigned WordW      = 32;

    // Header flag nibble, MSB first as it appears in W0.
    typedef struct packed {
        logic ovf;
        logic trap;
        logic intr;
        logic halt;
    } trace_flags_t;

    // One captured retirement.
    typedef struct packed {
        trace_flags_t        flags;
        logic [1:0]          mode;
        logic [4:0]          rd_addr;
        logic [OrderW-1:0]   order17;
        logic [WordW-1:0]    pc;
        logic [WordW-1:0]    insn;
        logic [WordW-1:0]    rd_wdata;
    } trace_rec_t;

    typedef enum logic [2:0] {
        TrIdle,
        TrW0,
        TrW1,
        TrW2,
        TrW3
    } trace_word_e;

    // Packet word 'sel' of a record; TrIdle yields zero.
    function automatic logic [WordW-1:0] trace_word(trace_rec_t rec, trace_word_e sel);
        logic [WordW-1:0] w;
        w = '0;
        case (sel)
            TrW0:    w = {TRACE_SYNC, rec.flags, rec.mode, rec.rd_addr, rec.order17};
            TrW1:    w = rec.pc;
            TrW2:    w = rec.insn;
            TrW3:    w = rec.rd_wdata;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ibex_rvfi_trace_sink_if.sv
// RVFI retirement inputs and the 32-bit trace word stream of the trace sink.
interface ibex_rvfi_trace_sink_if;

    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;

    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;

    // Core / downstream side.
    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, trace_ready_i,
        input  trace_valid_o, trace_data_o, trace_last_o
    );

    // Trace sink side.
    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
               rvfi_mode, rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, trace_ready_i,
        output trace_valid_o, trace_data_o, trace_last_o
    );

endinterface

// File: rtl/ibex_trace_rec_fifo.sv
// Depth x trace_rec_t synchronous FIFO; exposes the head and the entry behind it.
module ibex_trace_rec_fifo
    import ibex_rvfi_trace_sink_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  trace_rec_t                 data_i,
    input  logic                       pop_i,
    output trace_rec_t                 head_o,
    output trace_rec_t                 head_next_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    trace_rec_t         mem_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    rd_ptr_nxt;
    logic [LvlW-1:0]    level_q, level_d;
    logic               do_push, do_pop;

    assign full_o      = (level_q == LvlW'(Depth));
    assign empty_o     = (level_q == '0);
    assign level_o     = level_q;
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign rd_ptr_nxt  = rd_ptr_q + PtrW'(1);
    assign head_o      = mem_q[rd_ptr_q];
    assign head_next_o = mem_q[rd_ptr_nxt];

    // Pointer and occupancy next state; pointers wrap naturally at Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_sink.sv
// Captures RVFI retirements into a record FIFO and serializes them as 4-word trace packets.
module ibex_rvfi_trace_sink
    import ibex_rvfi_trace_sink_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       trace_en_i,
    ibex_rvfi_trace_sink_if.slave      bus,
    output logic [15:0]                drop_cnt_o,
    output logic [$clog2(Depth+1)-1:0] fifo_level_o
);

    localparam int unsigned LvlW = $clog2(Depth+1);

    trace_rec_t         push_rec;
    trace_rec_t         head, head_next;
    logic               full, empty;
    logic [LvlW-1:0]    level;
    logic               capture, push, drop, pop, handshake;

    trace_word_e        state_q;
    logic               valid_q;
    logic [WordW-1:0]   data_q;
    logic               last_q;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;

    logic               unused_order;
    assign unused_order = ^bus.rvfi_order[63:OrderW];

    assign capture   = bus.rvfi_valid && trace_en_i;
    assign push      = capture && !full;
    assign drop      = capture && full;
    assign handshake = valid_q && bus.trace_ready_i;
    assign pop       = handshake && (state_q == TrW3);

    // Record assembled from the current retirement; x0 writes are stored as zero.
    always_comb begin
        push_rec            = '0;
        push_rec.flags.ovf  = ovf_q;
        push_rec.flags.trap = bus.rvfi_trap;
        push_rec.flags.intr = bus.rvfi_intr;
        push_rec.flags.halt = bus.rvfi_halt;
        push_rec.mode       = bus.rvfi_mode;
        push_rec.rd_addr    = bus.rvfi_rd_addr;
        push_rec.order17    = bus.rvfi_order[OrderW-1:0];
        push_rec.pc         = bus.rvfi_pc_rdata;
        push_rec.insn       = bus.rvfi_insn;
        push_rec.rd_wdata   = (bus.rvfi_rd_addr == 5'd0) ? '0 : bus.rvfi_rd_wdata;
    end

    ibex_trace_rec_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .data_i      (push_rec),
        .pop_i       (pop),
        .head_o      (head),
        .head_next_o (head_next),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level)
    );

    // Drop counter saturates; overflow flag rides on the next accepted record.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (drop) begin
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
            ovf_d = 1'b1;
        end else if (push) begin
            ovf_d = 1'b0;
        end
    end

    // Drop counter and pending-overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Serializer: word data is registered one step ahead, using the entry behind
    // the head when a packet follows directly after W3.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TrIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                TrIdle: begin
                    if (!empty) begin
                        state_q <= TrW0;
                        valid_q <= 1'b1;
                        data_q  <= trace_word(head, TrW0);
                        last_q  <= 1'b0;
                    end
                end
                TrW0: begin
                    if (handshake) begin
                        state_q <= TrW1;
                        data_q  <= trace_word(head, TrW1);
                    end
                end
                TrW1: begin
                    if (handshake) begin
                        state_q <= TrW2;
                        data_q  <= trace_word(head, TrW2);
                    end
                end
                TrW2: begin
                    if (handshake) begin
                        state_q <= TrW3;
                        data_q  <= trace_word(head, TrW3);
                        last_q  <= 1'b1;
                    end
                end
                TrW3: begin
                    if (handshake) begin
                        last_q <= 1'b0;
                        if (level >= LvlW'(2)) begin
                            state_q <= TrW0;
                            data_q  <= trace_word(head_next, TrW0);
                        end else begin
                            state_q <= TrIdle;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= TrIdle;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trace_valid_o = valid_q;
    assign bus.trace_data_o  = data_q;
    assign bus.trace_last_o  = last_q;
    assign drop_cnt_o        = drop_cnt_q;
    assign fifo_level_o      = level;

endmodule
